// File: rtl/wb_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_writer_if
// Description : Writeback bus bundle: ALU/load result handshakes, load lock,
//               scoreboard query, register-file write and read/forward ports.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_writer_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;

    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;

    logic        lock_en;
    logic [4:0]  lock_addr;

    logic [4:0]  q_addr1;
    logic [4:0]  q_addr2;
    logic        q_busy1;
    logic        q_busy2;

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [31:0] rf_data1;
    logic [31:0] rf_data2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;

    logic        err_unlocked;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
               lock_en, lock_addr, q_addr1, q_addr2,
               rd_addr1, rd_addr2, rf_data1, rf_data2,
        input  alu_ready, mem_ready, q_busy1, q_busy2,
               wr_en, wr_addr, wr_data, fwd_data1, fwd_data2, err_unlocked
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
               lock_en, lock_addr, q_addr1, q_addr2,
               rd_addr1, rd_addr2, rf_data1, rf_data2,
        output alu_ready, mem_ready, q_busy1, q_busy2,
               wr_en, wr_addr, wr_data, fwd_data1, fwd_data2, err_unlocked
    );
endinterface
`default_nettype wire

// File: rtl/wb_writer.sv
`default_nettype none
// ============================================================================
// Module      : wb_writer
// Description : RV32I writeback stage: ALU/load arbitration, registered
//               register-file write port, load busy scoreboard and operand
//               forwarding. Define WB_FWD_EN to enable write-port forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_writer (
    input  wire logic  clk,
    input  wire logic  rst,
    wb_writer_if.slave bus
);

    typedef enum logic [0:0] {
        SRC_MEM = 1'b0,
        SRC_ALU = 1'b1
    } src_e;

    src_e        r_pref;
    src_e        w_pref_next;
    logic [31:0] r_busy;
    logic [31:0] w_busy_next;
    logic        r_wr_en;
    logic [4:0]  r_wr_addr;
    logic [31:0] r_wr_data;
    logic        r_err;

    logic        w_alu_fire;
    logic        w_mem_fire;
    logic        w_ld_en;
    logic [4:0]  w_ld_addr;
    logic [31:0] w_ld_data;
    logic        w_err_set;

    // Readies depend only on the other source's valid and the preference.
    assign bus.alu_ready = !(bus.mem_valid && (r_pref == SRC_MEM));
    assign bus.mem_ready = !(bus.alu_valid && (r_pref == SRC_ALU));
    assign w_alu_fire    = bus.alu_valid && bus.alu_ready;
    assign w_mem_fire    = bus.mem_valid && bus.mem_ready;

    always_comb begin
        w_pref_next = r_pref;
        w_busy_next = r_busy;
        w_ld_en     = 1'b0;
        w_ld_addr   = r_wr_addr;
        w_ld_data   = r_wr_data;
        w_err_set   = 1'b0;

        if (bus.alu_valid && bus.mem_valid)
            w_pref_next = (r_pref == SRC_MEM) ? SRC_ALU : SRC_MEM;

        // At most one source fires per cycle, so the output mux is a priority.
        if (w_mem_fire) begin
            w_busy_next[bus.mem_rd] = 1'b0;
            if (bus.mem_rd != 5'd0) begin
                w_ld_en   = 1'b1;
                w_ld_addr = bus.mem_rd;
                w_ld_data = bus.mem_data;
                w_err_set = !r_busy[bus.mem_rd];
            end
        end else if (w_alu_fire && (bus.alu_rd != 5'd0)) begin
            w_ld_en   = 1'b1;
            w_ld_addr = bus.alu_rd;
            w_ld_data = bus.alu_data;
        end

        // A new lock overrides a same-cycle clear of the same register.
        if (bus.lock_en)
            w_busy_next[bus.lock_addr] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pref    <= SRC_MEM;
            r_busy    <= 32'd0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 5'd0;
            r_wr_data <= 32'd0;
            r_err     <= 1'b0;
        end else begin
            r_pref    <= w_pref_next;
            r_busy    <= w_busy_next;
            r_wr_en   <= w_ld_en;
            r_wr_addr <= w_ld_addr;
            r_wr_data <= w_ld_data;
            r_err     <= r_err | w_err_set;
        end
    end

    assign bus.wr_en        = r_wr_en;
    assign bus.wr_addr      = r_wr_addr;
    assign bus.wr_data      = r_wr_data;
    assign bus.err_unlocked = r_err;
    assign bus.q_busy1      = r_busy[bus.q_addr1];
    assign bus.q_busy2      = r_busy[bus.q_addr2];

`ifdef WB_FWD_EN
    assign bus.fwd_data1 = (bus.rd_addr1 == 5'd0) ? 32'd0 :
                           (r_wr_en && (r_wr_addr == bus.rd_addr1)) ? r_wr_data :
                           bus.rf_data1;
    assign bus.fwd_data2 = (bus.rd_addr2 == 5'd0) ? 32'd0 :
                           (r_wr_en && (r_wr_addr == bus.rd_addr2)) ? r_wr_data :
                           bus.rf_data2;
`else
    assign bus.fwd_data1 = (bus.rd_addr1 == 5'd0) ? 32'd0 : bus.rf_data1;
    assign bus.fwd_data2 = (bus.rd_addr2 == 5'd0) ? 32'd0 : bus.rf_data2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_writer
// Description : Self-checking bench for wb_writer with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_writer;

    logic clk = 1'b0;
    logic rst;
    wb_writer_if bus();

    wb_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model of the visible state
    bit          m_pref_mem;
    bit          m_busy [32];
    bit          m_err;
    bit          m_wr_en;
    logic [4:0]  m_wr_addr;
    logic [31:0] m_wr_data;

    task automatic model_edge();
        bit ga;
        bit gm;
        ga = 1'b0;
        gm = 1'b0;
        if (rst) begin
            m_pref_mem = 1'b1;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_err     = 1'b0;
            m_wr_en   = 1'b0;
            m_wr_addr = 5'd0;
            m_wr_data = 32'd0;
        end else begin
            if (bus.alu_valid && bus.mem_valid) begin
                gm = m_pref_mem;
                ga = !m_pref_mem;
                m_pref_mem = !m_pref_mem;
            end else begin
                ga = bus.alu_valid;
                gm = bus.mem_valid;
            end
            if (gm && bus.mem_rd != 0 && !m_busy[bus.mem_rd]) m_err = 1'b1;
            m_wr_en = 1'b0;
            if (gm && bus.mem_rd != 0) begin
                m_wr_en = 1'b1; m_wr_addr = bus.mem_rd; m_wr_data = bus.mem_data;
            end
            if (ga && bus.alu_rd != 0) begin
                m_wr_en = 1'b1; m_wr_addr = bus.alu_rd; m_wr_data = bus.alu_data;
            end
            if (gm) m_busy[bus.mem_rd] = 1'b0;
            if (bus.lock_en && bus.lock_addr != 0) m_busy[bus.lock_addr] = 1'b1;
        end
    endtask

    function automatic logic [31:0] exp_fwd(logic [4:0] a, logic [31:0] rf);
        if (a == 5'd0) return 32'd0;
`ifdef WB_FWD_EN
        if (m_wr_en && m_wr_addr == a) return m_wr_data;
`endif
        return rf;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(bit av, logic [4:0] ard, logic [31:0] ad,
                         bit mv, logic [4:0] mrd, logic [31:0] md,
                         bit le, logic [4:0] la);
        bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
        bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_data = md;
        bus.lock_en   = le; bus.lock_addr = la;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
        checks++; if (bus.wr_addr !== 5'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d want 0", bus.wr_addr); end
        checks++; if (bus.wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", bus.wr_data); end
        checks++; if (bus.err_unlocked !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err_unlocked); end
        rst = 1'b0;
        bus.q_addr1 = 5'd7;
        drive(1, 1, 0, 1, 2, 0, 0, 0);
        #1;
        checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL reset_pref_alu_ready: got %b want 0", bus.alu_ready); end
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL reset_pref_mem_ready: got %b want 1", bus.mem_ready); end
        checks++; if (bus.q_busy1 !== 1'b0) begin errors++; $display("FAIL reset_q_busy: got %b want 0", bus.q_busy1); end
        idle();
        #1;
    endtask

    task automatic test_alu_stream();
        drive(1, 5, 32'h1234, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL alu_stream_ready[%0d]: got %b want 1", i, bus.alu_ready); end
            tick();
            checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd5 || bus.wr_data !== 32'h1234) begin
                errors++;
                $display("FAIL alu_stream_write[%0d]: got en=%b addr=%0d data=%h want en=1 addr=5 data=1234",
                         i, bus.wr_en, bus.wr_addr, bus.wr_data);
            end
        end
        idle();
    endtask

    task automatic test_conflict();
        logic [31:0] a;
        logic [31:0] b;
        bit          want_mem;
        a = $urandom;
        b = $urandom;
        bus.q_addr2 = 5'd2;
        drive(0, 0, 0, 0, 0, 0, 1, 2);
        #1;
        tick();
        drive(1, 1, a, 1, 2, b, 0, 0);
        for (int i = 0; i < 4; i++) begin
            want_mem = (i % 2 == 0);
            #1;
            checks++; if (bus.mem_ready !== want_mem || bus.alu_ready !== !want_mem) begin
                errors++;
                $display("FAIL conflict_grant[%0d]: got mem_ready=%b alu_ready=%b want mem_ready=%b",
                         i, bus.mem_ready, bus.alu_ready, want_mem);
            end
            tick();
            checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== (want_mem ? 5'd2 : 5'd1) ||
                          bus.wr_data !== (want_mem ? b : a)) begin
                errors++;
                $display("FAIL conflict_write[%0d]: got en=%b addr=%0d data=%h", i, bus.wr_en, bus.wr_addr, bus.wr_data);
            end
            if (i == 0) begin
                checks++; if (bus.q_busy2 !== 1'b0) begin errors++; $display("FAIL conflict_q_busy_x2: got %b want 0", bus.q_busy2); end
            end
        end
        idle();
    endtask

    task automatic test_x0();
        drive(1, 0, 32'hFFFF, 0, 0, 0, 0, 0);
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b want 1", bus.alu_ready); end
        tick();
        idle();
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL x0_wr_en: got %b want 0", bus.wr_en); end
        bus.rd_addr1 = 5'd0;
        bus.rf_data1 = $urandom | 32'h1;
        #1;
        checks++; if (bus.fwd_data1 !== 32'd0) begin errors++; $display("FAIL x0_fwd: got %h want 0", bus.fwd_data1); end
    endtask

    task automatic test_lock_and_err();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        bus.q_addr1 = 5'd7;
        drive(0, 0, 0, 0, 0, 0, 1, 7);
        #1;
        tick();
        idle();
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) drive(0, 0, 0, 1, 7, 32'h77, 0, 0);
            #1;
            checks++; if (bus.q_busy1 !== 1'b1) begin errors++; $display("FAIL lock_busy_cycle%0d: got %b want 1", c, bus.q_busy1); end
            tick();
        end
        idle();
        #1;
        checks++; if (bus.q_busy1 !== 1'b0) begin errors++; $display("FAIL lock_cleared: got %b want 0", bus.q_busy1); end
        checks++; if (bus.err_unlocked !== 1'b0) begin errors++; $display("FAIL lock_no_err: got %b want 0", bus.err_unlocked); end
        checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd7 || bus.wr_data !== 32'h77) begin
            errors++; $display("FAIL lock_load_write: got en=%b addr=%0d data=%h", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        drive(0, 0, 0, 1, 9, 32'h99, 0, 0);
        #1;
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            checks++; if (bus.err_unlocked !== 1'b1) begin errors++; $display("FAIL err_sticky[%0d]: got %b want 1", c, bus.err_unlocked); end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.err_unlocked !== 1'b0) begin errors++; $display("FAIL err_rst_clear: got %b want 0", bus.err_unlocked); end
    endtask

    task automatic test_forward();
        drive(1, 3, 32'hDEAD, 0, 0, 0, 0, 0);
        #1;
        tick();
        idle();
        bus.rd_addr2 = 5'd3;
        bus.rf_data2 = 32'hBEEF;
        #1;
        checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd3) begin
            errors++; $display("FAIL fwd_setup: got en=%b addr=%0d want en=1 addr=3", bus.wr_en, bus.wr_addr);
        end
`ifdef WB_FWD_EN
        checks++; if (bus.fwd_data2 !== 32'hDEAD) begin errors++; $display("FAIL fwd_data2: got %h want dead", bus.fwd_data2); end
`else
        checks++; if (bus.fwd_data2 !== 32'hBEEF) begin errors++; $display("FAIL fwd_data2: got %h want beef", bus.fwd_data2); end
`endif
        tick();
    endtask

    task automatic test_reset_mid();
        if (m_pref_mem) begin
            drive(1, 0, 0, 1, 0, 0, 0, 0);
            #1;
            tick();
        end
        bus.q_addr1 = 5'd4;
        drive(1, 6, $urandom, 0, 0, 0, 1, 4);
        #1;
        tick();
        idle();
        checks++; if (bus.wr_en !== 1'b1 || bus.q_busy1 !== 1'b1) begin
            errors++; $display("FAIL rstmid_setup: got en=%b busy4=%b want 1 1", bus.wr_en, bus.q_busy1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr_en: got %b want 0", bus.wr_en); end
        checks++; if (bus.q_busy1 !== 1'b0) begin errors++; $display("FAIL rstmid_busy4: got %b want 0", bus.q_busy1); end
        drive(1, 1, 0, 1, 2, 0, 0, 0);
        #1;
        checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_pref: got mem_ready=%b alu_ready=%b want 1 0", bus.mem_ready, bus.alu_ready);
        end
        idle();
        #1;
    endtask

    task automatic test_random();
        bit av;
        bit mv;
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        for (int n = 0; n < 400; n++) begin
            av = ($urandom % 2) == 1;
            mv = ($urandom % 2) == 1;
            drive(av, 5'($urandom % 8), $urandom, mv, 5'($urandom % 8), $urandom,
                  ($urandom % 3) == 0, 5'($urandom % 8));
            bus.q_addr1  = 5'($urandom % 8);
            bus.q_addr2  = 5'($urandom % 8);
            bus.rd_addr1 = 5'($urandom % 8);
            bus.rd_addr2 = 5'($urandom % 8);
            bus.rf_data1 = $urandom;
            bus.rf_data2 = $urandom;
            #1;
            checks++; if (bus.alu_ready !== !(mv && m_pref_mem) || bus.mem_ready !== !(av && !m_pref_mem)) begin
                errors++; $display("FAIL rand_ready[%0d]: got alu=%b mem=%b", n, bus.alu_ready, bus.mem_ready);
            end
            checks++; if (bus.fwd_data1 !== exp_fwd(bus.rd_addr1, bus.rf_data1) ||
                          bus.fwd_data2 !== exp_fwd(bus.rd_addr2, bus.rf_data2)) begin
                errors++; $display("FAIL rand_fwd[%0d]: got %h %h want %h %h", n, bus.fwd_data1, bus.fwd_data2,
                                   exp_fwd(bus.rd_addr1, bus.rf_data1), exp_fwd(bus.rd_addr2, bus.rf_data2));
            end
            checks++; if (bus.q_busy1 !== m_busy[bus.q_addr1] || bus.q_busy2 !== m_busy[bus.q_addr2]) begin
                errors++; $display("FAIL rand_q_busy[%0d]: got %b %b want %b %b", n, bus.q_busy1, bus.q_busy2,
                                   m_busy[bus.q_addr1], m_busy[bus.q_addr2]);
            end
            tick();
            checks++; if (bus.wr_en !== m_wr_en || bus.wr_addr !== m_wr_addr || bus.wr_data !== m_wr_data) begin
                errors++; $display("FAIL rand_write[%0d]: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h",
                                   n, bus.wr_en, bus.wr_addr, bus.wr_data, m_wr_en, m_wr_addr, m_wr_data);
            end
            checks++; if (bus.err_unlocked !== m_err) begin
                errors++; $display("FAIL rand_err[%0d]: got %b want %b", n, bus.err_unlocked, m_err);
            end
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus.q_addr1 = 0; bus.q_addr2 = 0;
        bus.rd_addr1 = 0; bus.rd_addr2 = 0;
        bus.rf_data1 = 0; bus.rf_data2 = 0;
        test_reset();
        test_alu_stream();
        test_conflict();
        test_x0();
        test_lock_and_err();
        test_forward();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
